// File: rtl/sort_pkg.sv
// ============================================================================
//  Module      : sort_pkg
//  Description : Shared record types, decoupler state encoding and width
//                helper for the coupling/decoupling stages of the sorter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sort_pkg;

    localparam int c_DEFAULT_DATA_WIDTH   = 32;
    localparam int c_DEFAULT_BUNDLE_WIDTH = 8;

    // Payload width of one narrow record: elements times element width.
    function automatic int narrow_width(input int data_width, input int bundle_width);
        return data_width * bundle_width;
    endfunction

    localparam int c_DEFAULT_NW = narrow_width(c_DEFAULT_DATA_WIDTH, c_DEFAULT_BUNDLE_WIDTH);

    typedef struct packed {
        logic                    last;
        logic [c_DEFAULT_NW-1:0] data;
    } narrow_rec_t;

    typedef struct packed {
        logic                    last;
        logic [c_DEFAULT_NW-1:0] high;
        logic [c_DEFAULT_NW-1:0] low;
    } wide_rec_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOW   = 2'd1,
        HIGH  = 2'd2
    } dec_state_t;

endpackage

`default_nettype wire

// File: rtl/decoupler_if.sv
// ============================================================================
//  Module      : decoupler_if
//  Description : Upstream show-ahead FIFO drain port plus downstream
//                valid/ready narrow-record stream of the decoupler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decoupler_if
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUNDLE_WIDTH = 8
);
    localparam int c_NW = narrow_width(DATA_WIDTH, BUNDLE_WIDTH);

    logic [2*c_NW:0] i_fifo_data;
    logic            i_fifo_empty;
    logic            o_fifo_read;
    logic [c_NW:0]   o_data;
    logic            o_valid;
    logic            i_ready;

    // slave: the decoupler itself; master: the surrounding FIFO and consumer.
    modport slave (
        input  i_fifo_data,
        input  i_fifo_empty,
        input  i_ready,
        output o_fifo_read,
        output o_data,
        output o_valid
    );

    modport master (
        output i_fifo_data,
        output i_fifo_empty,
        output i_ready,
        input  o_fifo_read,
        input  o_data,
        input  o_valid
    );

endinterface

`default_nettype wire

// File: rtl/decoupler_skid_buffer.sv
// ============================================================================
//  Module      : skid_buffer
//  Description : Two-entry valid/ready skid buffer; upstream ready is a
//                registered not-full flag, so no combinational ready path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst,
    input  wire logic             i_valid,
    output logic                  o_ready,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  wire logic             i_ready,
    output logic [WIDTH-1:0]      o_data
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_in_fire;

    assign w_in_fire = i_valid && !r_skid_valid;

    // The skid entry only fills when the output entry is stalled, so a
    // transfer is never accepted while both entries are occupied.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (!r_out_valid || i_ready) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_out_data <= i_data;
                end
            end
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_data;
        end
    end

    assign o_ready = !r_skid_valid;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

endmodule

`default_nettype wire

// File: rtl/decoupler.sv
// ============================================================================
//  Module      : decoupler
//  Description : Splits 2:1 coupled wide records from a show-ahead FIFO into
//                low-then-high narrow {last, data} records on valid/ready.
//                Optional output skid buffer: define DECOUPLER_OUT_SKID_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoupler
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUNDLE_WIDTH = 8
) (
    input  wire logic  i_clk,
    input  wire logic  i_rst,
    decoupler_if.slave bus
);

    localparam int c_NW = narrow_width(DATA_WIDTH, BUNDLE_WIDTH);

    typedef struct packed {
        logic            last;
        logic [c_NW-1:0] high;
        logic [c_NW-1:0] low;
    } wide_t;

    typedef struct packed {
        logic            last;
        logic [c_NW-1:0] data;
    } narrow_t;

    dec_state_t r_state;
    dec_state_t w_next;
    wide_t      r_hold;
    logic       w_pop;
    logic       w_fsm_valid;
    logic       w_fsm_ready;
    narrow_t    w_fsm_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= EMPTY;
            r_hold  <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop) begin
                r_hold <= bus.i_fifo_data;
            end
        end
    end

    // Popping in HIGH alongside the final transfer keeps the stream bubble-free.
    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_fsm_valid = 1'b0;
        w_fsm_data  = '0;
        case (r_state)
            EMPTY: begin
                w_pop = !bus.i_fifo_empty;
                if (w_pop) begin
                    w_next = LOW;
                end
            end
            LOW: begin
                w_fsm_valid = 1'b1;
                w_fsm_data  = {1'b0, r_hold.low};
                if (w_fsm_ready) begin
                    w_next = HIGH;
                end
            end
            HIGH: begin
                w_fsm_valid = 1'b1;
                w_fsm_data  = {r_hold.last, r_hold.high};
                if (w_fsm_ready) begin
                    w_pop = !bus.i_fifo_empty;
                    if (w_pop) begin
                        w_next = LOW;
                    end else begin
                        w_next = EMPTY;
                    end
                end
            end
            default: begin
                w_next = EMPTY;
            end
        endcase
        if (i_rst) begin
            w_pop       = 1'b0;
            w_fsm_valid = 1'b0;
            w_fsm_data  = '0;
        end
    end

    assign bus.o_fifo_read = w_pop;

`ifdef DECOUPLER_OUT_SKID_EN
    logic          w_skid_valid;
    logic [c_NW:0] w_skid_data;

    skid_buffer #(
        .WIDTH (c_NW + 1)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (w_fsm_valid),
        .o_ready (w_fsm_ready),
        .i_data  (w_fsm_data),
        .o_valid (w_skid_valid),
        .i_ready (bus.i_ready),
        .o_data  (w_skid_data)
    );

    assign bus.o_valid = w_skid_valid && !i_rst;
    assign bus.o_data  = i_rst ? '0 : w_skid_data;
`else
    assign w_fsm_ready = bus.i_ready;
    assign bus.o_valid = w_fsm_valid;
    assign bus.o_data  = w_fsm_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decoupler.sv
// ============================================================================
//  Module      : tb_decoupler
//  Description : Self-checking bench for decoupler: directed timing cases and
//                a randomized run against a word-to-halves reference queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoupler;

    localparam int DW = 8;
    localparam int BW = 1;
    localparam int NW = DW * BW;
`ifdef DECOUPLER_OUT_SKID_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decoupler_if #(.DATA_WIDTH(DW), .BUNDLE_WIDTH(BW)) bus ();

    decoupler #(.DATA_WIDTH(DW), .BUNDLE_WIDTH(BW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic          ready_drv  = 1'b0;
    logic          rst_drv    = 1'b1;
    logic          sb_on      = 1'b0;
    logic          stall_prev = 1'b0;
    logic [NW:0]   prev_d     = '0;
    logic [2*NW:0] fifo_q[$];
    logic [NW:0]   exp_q[$];
    logic [NW:0]   xfer_q[$];
    logic [NW:0]   ld[$];
    logic          lv[$];
    logic          lr[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // Reference: each wide word expands to {0,low} followed by {last,high}.
    task automatic push_word(input logic [2*NW:0] w);
        fifo_q.push_back(w);
        exp_q.push_back({1'b0, w[NW-1:0]});
        exp_q.push_back({w[2*NW], w[2*NW-1:NW]});
    endtask

    task automatic cycle();
        logic          s_v;
        logic          s_r;
        logic [NW:0]   s_d;
        @(negedge clk);
        rst              = rst_drv;
        bus.i_ready      = ready_drv;
        bus.i_fifo_empty = (fifo_q.size() == 0);
        bus.i_fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
        #1;
        s_v = bus.o_valid;
        s_d = bus.o_data;
        s_r = bus.o_fifo_read;
        lv.push_back(s_v);
        ld.push_back(s_d);
        lr.push_back(s_r);
        if (bus.i_fifo_empty) check("read_when_empty", 32'(s_r), 32'(0));
        if (stall_prev && !rst_drv) begin
            check("stall_valid", 32'(s_v), 32'(1));
            check("stall_data", 32'(s_d), 32'(prev_d));
        end
        @(posedge clk);
        if (s_r && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (s_v && ready_drv && !rst_drv) begin
            xfer_q.push_back(s_d);
            if (sb_on) begin
                if (exp_q.size() == 0) check("sb_extra", 32'(s_d), 32'hFFFF_FFFF);
                else                   check("sb_data", 32'(s_d), 32'(exp_q.pop_front()));
            end
        end
        stall_prev = s_v && !ready_drv && !rst_drv;
        prev_d     = s_d;
    endtask

    task automatic clear_logs();
        ld.delete(); lv.delete(); lr.delete(); xfer_q.delete();
    endtask

    task automatic begin_test();
        ready_drv = 1'b1;
        repeat (4) cycle();
        clear_logs();
    endtask

    initial begin
        logic        any_v;
        logic        any_r;
        int          n0;
        int          pushed;
        int          cyc;
        logic [31:0] rnd;

        bus.i_ready      = 1'b0;
        bus.i_fifo_empty = 1'b1;
        bus.i_fifo_data  = '0;

        // Reset with data waiting upstream: nothing may be popped or shown.
        clear_logs();
        rst_drv = 1'b1;
        push_word(17'h1_5A5A);
        repeat (3) cycle();
        check("rst_read", 32'(lr[2]), 32'(0));
        check("rst_valid", 32'(lv[2]), 32'(0));
        check("rst_data", 32'(ld[2]), 32'(0));
        fifo_q.delete();
        exp_q.delete();
        rst_drv = 1'b0;
        cycle();
        check("post_rst_valid", 32'(lv[3]), 32'(0));

        // Single word.
        begin_test();
        push_word(17'h1_BBAA);
        repeat (LAT + 4) cycle();
        check("single_pop", 32'(lr[0]), 32'(1));
        check("single_lat_valid", 32'(lv[0]), 32'(0));
        check("single_low_valid", 32'(lv[LAT]), 32'(1));
        check("single_low", 32'(ld[LAT]), 32'h0AA);
        check("single_high", 32'(ld[LAT+1]), 32'h1BB);
        check("single_tail_valid", 32'(lv[LAT+2]), 32'(0));

        // Back-to-back words.
        begin_test();
        push_word(17'h0_2211);
        push_word(17'h1_4433);
        repeat (LAT + 6) cycle();
        check("b2b_pop0", 32'(lr[0]), 32'(1));
        check("b2b_pop1", 32'(lr[2]), 32'(1));
        check("b2b_d0", 32'(ld[LAT]), 32'h011);
        check("b2b_d1", 32'(ld[LAT+1]), 32'h022);
        check("b2b_d2", 32'(ld[LAT+2]), 32'h033);
        check("b2b_d3", 32'(ld[LAT+3]), 32'h144);
        check("b2b_tail_valid", 32'(lv[LAT+4]), 32'(0));

        // Backpressure for 5 cycles while the low half is presented.
        begin_test();
        ready_drv = 1'b0;
        push_word(17'h0_2211);
        push_word(17'h1_4433);
        repeat (6) cycle();
        check("bp_valid", 32'(lv[5]), 32'(1));
        check("bp_data", 32'(ld[5]), 32'h011);
`ifndef DECOUPLER_OUT_SKID_EN
        any_r = 1'b0;
        for (int i = 1; i <= 5; i++) any_r |= lr[i];
        check("bp_no_pop", 32'(any_r), 32'(0));
`endif
        ready_drv = 1'b1;
        repeat (8) cycle();
        check("bp_count", 32'(xfer_q.size()), 32'(4));
        check("bp_x0", 32'(xfer_q[0]), 32'h011);
        check("bp_x1", 32'(xfer_q[1]), 32'h022);
        check("bp_x2", 32'(xfer_q[2]), 32'h033);
        check("bp_x3", 32'(xfer_q[3]), 32'h144);

        // Upstream stays empty.
        begin_test();
        repeat (20) cycle();
        any_v = 1'b0;
        any_r = 1'b0;
        for (int i = 0; i < 20; i++) begin
            any_v |= lv[i];
            any_r |= lr[i];
        end
        check("idle_valid", 32'(any_v), 32'(0));
        check("idle_read", 32'(any_r), 32'(0));

        // Reset while the high half is pending.
        begin_test();
        push_word(17'h1_BBAA);
        repeat (2) cycle();
        rst_drv = 1'b1;
        cycle();
        rst_drv = 1'b0;
        cycle();
        check("midrst_valid", 32'(lv[3]), 32'(0));
        check("midrst_data", 32'(ld[3]), 32'(0));
        n0 = xfer_q.size();
        push_word(17'h0_DDCC);
        repeat (LAT + 3) cycle();
        check("midrst_pop", 32'(lr[4]), 32'(1));
        check("midrst_count", 32'(xfer_q.size()), 32'(n0 + 2));
        check("midrst_low", 32'(xfer_q[n0]), 32'h0CC);
        check("midrst_high", 32'(xfer_q[n0+1]), 32'h0DD);

        // Randomized traffic against the reference queue.
        begin_test();
        exp_q.delete();
        fifo_q.delete();
        sb_on  = 1'b1;
        pushed = 0;
        cyc    = 0;
        while (xfer_q.size() < 2000 && cyc < 20000) begin
            if (pushed < 1000 && fifo_q.size() < 3 && $urandom_range(0, 1) == 1) begin
                rnd = $urandom;
                push_word(rnd[2*NW:0]);
                pushed++;
            end
            ready_drv = ($urandom_range(0, 1) == 1);
            cycle();
            cyc++;
        end
        sb_on = 1'b0;
        check("rand_xfers", 32'(xfer_q.size()), 32'(2000));
        check("rand_leftover", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
